e_out_port_alloc_ctrl: RTL and testbench
========================================

Name: e_out_port_alloc_ctrl

Overview:
- Per-output-port allocation sequencer for the east output of the NOC router, placed downstream of the east round-robin arbiter.
- Latches the arbiter's one-hot grant and holds the port for the whole wormhole packet, head through tail.
- Drives crossbar select and input-buffer pops, tracks downstream credits, and pulses the arbiter's priority-rotate input when a packet completes.

Parameters:
- CREDIT_DEPTH, 4, downstream input-buffer depth; credit counter reset value.
- CNT_W, $clog2(CREDIT_DEPTH+1), credit counter width (derived).
- WDOG_CYCLES, 64, stall cycles before forced release (used only with OPC_WATCHDOG_EN).

Ports:
- clk  in  1  router clock
- reset  in  1  asynchronous, active-low reset
- grant_n_i / grant_s_i / grant_w_i / grant_l_i  in  1 each  one-hot grants from the east arbiter
- flit_valid_i  in  4  head-flit valid per input, bit order {n,s,w,l}
- flit_tail_i  in  4  head flit is the packet tail, same bit order
- credit_return_i  in  1  downstream freed one slot
- xbar_sel_o  out  3  crossbar source code
- xbar_valid_o  out  1  flit crosses to east this cycle
- pop_o  out  4  one-hot dequeue to the owner input buffer, {n,s,w,l}
- credit_avail_o  out  1  credit count is nonzero; feeds the arbiter's downstream-credit input
- change_order_o  out  1  one-cycle rotate pulse to the round-robin registers
- locked_o  out  1  port owned by a packet
- credit_cnt_o  out  CNT_W  current credit count
- wdog_timeout_o  out  1  present only with OPC_WATCHDOG_EN

Behaviour:
- Port codes: N=3'b000, S=3'b001, W=3'b010, E/idle=3'b011, L=3'b100.
- Reset values: FSM=IDLE, owner cleared, xbar_sel_o=3'b011, credit_cnt_o=CREDIT_DEPTH, credit_avail_o=1. All other outputs are 0.
- IDLE state:
  - xbar_sel_o=3'b011; pop_o=0; xbar_valid_o=0; locked_o=0.
  - A grant seen while change_order_o=0 latches the owner at the clock edge and moves to LOCKED.
  - The first flit can move in the following cycle, so grant-to-first-flit latency is 1 cycle.
  - A grant arriving while change_order_o=1 is ignored, because the arbiter order is stale that cycle.
  - More than one grant high is a protocol violation; resolve deterministically with priority N>S>W>L.
- LOCKED state:
  - locked_o=1; xbar_sel_o=owner code.
  - Send condition is combinational: flit_valid_i[owner] AND credit_cnt>0. When true, assert pop_o[owner]=1 and xbar_valid_o=1.
  - A send with flit_tail_i[owner]=1 moves to IDLE at the edge. change_order_o is registered high for exactly the next cycle.
  - A single-flit packet (head = tail) follows the same path.
  - No valid flit or no credit: stall in LOCKED with outputs held.
- Credit counter:
  - Send only: decrement. Return only: increment. Send and return in the same cycle: unchanged.
  - A return at CREDIT_DEPTH saturates; count stays.
  - Underflow is impossible because send requires credit_cnt>0.
  - credit_avail_o = (credit_cnt != 0), combinational.
- Reset asserted mid-packet: immediate return to reset values. No change_order_o pulse; the partial packet is abandoned.

Optional Feature:
- Macro: OPC_WATCHDOG_EN.
- Enabled:
  - In LOCKED, a stall counter increments on each cycle without a send and clears on each send.
  - When the counter reaches WDOG_CYCLES-1, force IDLE and pulse change_order_o the next cycle.
  - wdog_timeout_o sets and stays sticky until reset.
- Disabled: no counter, no wdog_timeout_o port, and the lock is held indefinitely.

Decomposition:
- Package noc_router_pkg holds:
  - port-code localparams PORT_N, PORT_S, PORT_W, PORT_E_IDLE, PORT_L
  - typedef enum logic {IDLE, LOCKED} opc_state_t
  - default CREDIT_DEPTH
- One sub-module: noc_credit_counter, parameterised by CREDIT_DEPTH, with saturating up/down counting and a nonzero flag.

Test Plan:
- Reset (depth 4) -> credit_cnt_o=4, xbar_sel_o=3'b011, credit_avail_o=1, all other outputs 0.
- grant_w_i pulse, W has a 3-flit packet, no returns:
  - pop_o=4'b0010 for 3 consecutive cycles starting 1 cycle after the grant, xbar_sel_o=3'b010.
  - credit_cnt_o goes 4->1; change_order_o high 1 cycle after the tail, locked_o falls.
- 6-flit packet from N, no returns -> 4 flits sent, then pop_o=0 and credit_avail_o=0 with locked_o held; one credit_return_i pulse -> exactly one more flit.
- Send coinciding with credit_return_i at count 2 -> count stays 2; return at count 4 -> stays 4.
- grant_s_i asserted during the change_order_o cycle -> ignored, stays IDLE; re-asserted next cycle -> LOCKED with sel 3'b001.
- reset low mid-packet -> all outputs return to reset values immediately.
- With OPC_WATCHDOG_EN: owner stalls 64 cycles -> forced IDLE, change_order_o pulse, wdog_timeout_o=1.

Source files
------------

// File: rtl/noc_router_pkg.sv
// Shared definitions for the NOC router output-port allocation logic:
// crossbar source codes, allocation FSM states and the default credit depth.
package noc_router_pkg;

   localparam logic [2:0] PORT_N      = 3'b000;
   localparam logic [2:0] PORT_S      = 3'b001;
   localparam logic [2:0] PORT_W      = 3'b010;
   localparam logic [2:0] PORT_E_IDLE = 3'b011;
   localparam logic [2:0] PORT_L      = 3'b100;

   localparam int DEF_CREDIT_DEPTH = 4;

   typedef enum logic {IDLE, LOCKED} opc_state_t;

   // One-hot owner {n,s,w,l} to crossbar source code.
   function automatic logic [2:0] port_code(input logic [3:0] owner);
      case (owner)
         4'b1000: return PORT_N;
         4'b0100: return PORT_S;
         4'b0010: return PORT_W;
         4'b0001: return PORT_L;
         default: return PORT_E_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/noc_credit_counter.sv
// Downstream credit counter: resets full, counts down on send and up on return,
// saturates at CREDIT_DEPTH and flags a nonzero count.
module noc_credit_counter
   import noc_router_pkg::*;
#(
   parameter int CREDIT_DEPTH = DEF_CREDIT_DEPTH,
   parameter int CNT_W        = $clog2(CREDIT_DEPTH + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc_i,
   input  logic             dec_i,
   output logic [CNT_W-1:0] cnt_o,
   output logic             nonzero_o
);

   localparam logic [CNT_W-1:0] FULL = CNT_W'(CREDIT_DEPTH);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   // Simultaneous send and return cancel out.
   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && !dec_i && (cnt_q != FULL)) begin
         cnt_d = cnt_q + 1'b1;
      end else if (dec_i && !inc_i && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= FULL;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o     = cnt_q;
   assign nonzero_o = (cnt_q != '0);

endmodule

// File: rtl/e_out_port_alloc_ctrl.sv
// East output-port allocation sequencer: holds the port for a wormhole packet,
// drives crossbar select / buffer pops and rotates the arbiter on completion.
// Optional stall watchdog enabled by defining OPC_WATCHDOG_EN.
module e_out_port_alloc_ctrl
   import noc_router_pkg::*;
#(
   parameter int CREDIT_DEPTH = DEF_CREDIT_DEPTH,
   parameter int CNT_W        = $clog2(CREDIT_DEPTH + 1)
`ifdef OPC_WATCHDOG_EN
   ,
   parameter int WDOG_CYCLES  = 64
`endif
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             grant_n_i,
   input  logic             grant_s_i,
   input  logic             grant_w_i,
   input  logic             grant_l_i,
   input  logic [3:0]       flit_valid_i,
   input  logic [3:0]       flit_tail_i,
   input  logic             credit_return_i,
   output logic [2:0]       xbar_sel_o,
   output logic             xbar_valid_o,
   output logic [3:0]       pop_o,
   output logic             credit_avail_o,
   output logic             change_order_o,
   output logic             locked_o,
   output logic [CNT_W-1:0] credit_cnt_o
`ifdef OPC_WATCHDOG_EN
   ,
   output logic             wdog_timeout_o
`endif
);

   opc_state_t state_q, state_d;
   logic [3:0] owner_q, owner_d;
   logic       change_order_q, change_order_d;
   logic [3:0] grant_vec, grant_pick;
   logic       send, tail_send, wdog_fire;

   assign grant_vec = {grant_n_i, grant_s_i, grant_w_i, grant_l_i};

   // Several grants at once is an arbiter bug; resolve N > S > W > L.
   always_comb begin
      grant_pick = 4'b0000;
      if (grant_vec[3])      grant_pick = 4'b1000;
      else if (grant_vec[2]) grant_pick = 4'b0100;
      else if (grant_vec[1]) grant_pick = 4'b0010;
      else if (grant_vec[0]) grant_pick = 4'b0001;
   end

   assign send      = (state_q == LOCKED) && (|(flit_valid_i & owner_q)) && credit_avail_o;
   assign tail_send = send && (|(flit_tail_i & owner_q));

   always_comb begin
      state_d        = state_q;
      owner_d        = owner_q;
      change_order_d = 1'b0;
      xbar_sel_o     = PORT_E_IDLE;
      locked_o       = 1'b0;
      case (state_q)
         IDLE: begin
            // The arbiter order is stale during the rotate pulse.
            if ((|grant_vec) && !change_order_q) begin
               state_d = LOCKED;
               owner_d = grant_pick;
            end
         end
         LOCKED: begin
            locked_o   = 1'b1;
            xbar_sel_o = port_code(owner_q);
            if (tail_send || wdog_fire) begin
               state_d        = IDLE;
               owner_d        = 4'b0000;
               change_order_d = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q        <= IDLE;
         owner_q        <= 4'b0000;
         change_order_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         owner_q        <= owner_d;
         change_order_q <= change_order_d;
      end
   end

   assign pop_o          = send ? owner_q : 4'b0000;
   assign xbar_valid_o   = send;
   assign change_order_o = change_order_q;

   noc_credit_counter #(
      .CREDIT_DEPTH (CREDIT_DEPTH),
      .CNT_W        (CNT_W)
   ) u_credit (
      .clk       (clk),
      .reset     (reset),
      .inc_i     (credit_return_i),
      .dec_i     (send),
      .cnt_o     (credit_cnt_o),
      .nonzero_o (credit_avail_o)
   );

`ifdef OPC_WATCHDOG_EN
   localparam int WD_W = $clog2(WDOG_CYCLES);

   logic [WD_W-1:0] stall_q, stall_d;
   logic            wdog_q, wdog_d;

   assign wdog_fire = (state_q == LOCKED) && !send && (stall_q == WD_W'(WDOG_CYCLES - 1));

   always_comb begin
      wdog_d  = wdog_q | wdog_fire;
      stall_d = stall_q + 1'b1;
      if ((state_q != LOCKED) || send || wdog_fire) begin
         stall_d = '0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         stall_q <= '0;
         wdog_q  <= 1'b0;
      end else begin
         stall_q <= stall_d;
         wdog_q  <= wdog_d;
      end
   end

   assign wdog_timeout_o = wdog_q;
`else
   assign wdog_fire = 1'b0;
`endif

endmodule

// File: tb/tb_e_out_port_alloc_ctrl.sv
// Bench for e_out_port_alloc_ctrl: directed protocol cases plus randomized
// packets, flits checked by a scoreboard monitor against a credit/flit model.
module tb_e_out_port_alloc_ctrl;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk = 1'b0;
   logic          rst_n;
   logic          grant_n, grant_s, grant_w, grant_l;
   logic [3:0]    flit_valid, flit_tail;
   logic          credit_return;
   logic [2:0]    xbar_sel;
   logic          xbar_valid;
   logic [3:0]    pop;
   logic          credit_avail, change_order, locked;
   logic [CW-1:0] credit_cnt;
`ifdef OPC_WATCHDOG_EN
   logic          wdog_timeout;
`endif

   int         errors = 0;
   int         checks = 0;
   logic [7:0] exp_q[$];          // {tail, sel[2:0], pop[3:0]}
   int         buf_len[4];        // flits left in each input buffer (index = bit position)
   logic [3:0] last_pop = 4'b0000;
   int         exp_credit = DEPTH;
   logic       co_exp = 1'b0;
   bit         mon_co_en = 1'b1;
   bit         bubble_en = 1'b0;
   bit         ret_rand = 1'b0;

   e_out_port_alloc_ctrl #(.CREDIT_DEPTH(DEPTH)) dut (
      .clk             (clk),
      .reset           (rst_n),
      .grant_n_i       (grant_n),
      .grant_s_i       (grant_s),
      .grant_w_i       (grant_w),
      .grant_l_i       (grant_l),
      .flit_valid_i    (flit_valid),
      .flit_tail_i     (flit_tail),
      .credit_return_i (credit_return),
      .xbar_sel_o      (xbar_sel),
      .xbar_valid_o    (xbar_valid),
      .pop_o           (pop),
      .credit_avail_o  (credit_avail),
      .change_order_o  (change_order),
      .locked_o        (locked),
      .credit_cnt_o    (credit_cnt)
`ifdef OPC_WATCHDOG_EN
      ,
      .wdog_timeout_o  (wdog_timeout)
`endif
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [2:0] src_code(input int i);
      case (i)
         3:       return 3'b000;
         2:       return 3'b001;
         1:       return 3'b010;
         default: return 3'b100;
      endcase
   endfunction

   task automatic push_pkt(input int i, input int len);
      for (int k = 0; k < len; k++) begin
         exp_q.push_back({(k == len - 1), src_code(i), 4'(1 << i)});
      end
   endtask

   task automatic load(input int i, input int len);
      buf_len[i] = len;
   endtask

   task automatic grant(input logic [3:0] g);
      grant_n = g[3];
      grant_s = g[2];
      grant_w = g[1];
      grant_l = g[0];
   endtask

   // Advance one cycle: retire popped flits, then drive the new cycle's inputs.
   task automatic tick();
      @(posedge clk);
      for (int i = 0; i < 4; i++) begin
         if (last_pop[i] && buf_len[i] > 0) buf_len[i]--;
      end
      #1;
      for (int i = 0; i < 4; i++) begin
         flit_valid[i] = (buf_len[i] > 0) && !(bubble_en && $urandom_range(0, 3) == 0);
         flit_tail[i]  = (buf_len[i] == 1);
      end
      grant(4'b0000);
      credit_return = ret_rand && ($urandom_range(0, 2) == 0);
   endtask

   task automatic ret_n(input int n);
      for (int k = 0; k < n; k++) begin
         credit_return = 1'b1;
         tick();
      end
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 400) begin
         tick();
         n++;
      end
      chk("drain", exp_q.size(), 0);
      if (exp_q.size() != 0) begin
         exp_q.delete();
         for (int i = 0; i < 4; i++) buf_len[i] = 0;
      end
      tick();
   endtask

   // ---------------- scoreboard monitor ----------------
   always @(negedge clk) begin
      logic [7:0] e;
      last_pop = pop;
      if (!rst_n) begin
         exp_credit = DEPTH;
         co_exp     = 1'b0;
      end else begin
         chk("credit_cnt", credit_cnt, exp_credit);
         chk("credit_avail", credit_avail, exp_credit != 0);
         if (mon_co_en) chk("change_order", change_order, co_exp);
         co_exp = 1'b0;
         if (xbar_valid) begin
            chk("send_credit", exp_credit != 0, 1);
            if (exp_q.size() == 0) begin
               chk("flit_expected", exp_q.size(), 1);
            end else begin
               e = exp_q.pop_front();
               chk("flit_sel", xbar_sel, e[6:4]);
               chk("flit_pop", pop, e[3:0]);
               co_exp = e[7];
            end
         end else begin
            chk("idle_pop", pop, 0);
         end
         if (xbar_valid && !credit_return && exp_credit > 0) exp_credit--;
         else if (credit_return && !xbar_valid && exp_credit < DEPTH) exp_credit++;
      end
   end

   // ---------------- time limit ----------------
   initial begin
      #500000;
      errors++;
      $display("FAIL time_limit: simulation did not finish");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "time limit");
   end

   // ---------------- stimulus ----------------
   initial begin
      int i, len;
      rst_n         = 1'b0;
      grant(4'b0000);
      flit_valid    = 4'b0000;
      flit_tail     = 4'b0000;
      credit_return = 1'b0;
      for (int k = 0; k < 4; k++) buf_len[k] = 0;

      repeat (2) @(posedge clk);
      #1;
      chk("rst_credit", credit_cnt, 4);
      chk("rst_sel", xbar_sel, 3'b011);
      chk("rst_avail", credit_avail, 1);
      chk("rst_locked", locked, 0);
      chk("rst_pop", pop, 0);
      chk("rst_valid", xbar_valid, 0);
      chk("rst_co", change_order, 0);
      tick();
      rst_n = 1'b1;
      tick();

      // W, 3-flit packet, no returns
      load(1, 3);
      tick();
      grant(4'b0010);
      push_pkt(1, 3);
      #3 chk("w_grant_locked", locked, 0);
      chk("w_grant_pop", pop, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         #3 chk("w_pop", pop, 4'b0010);
         chk("w_sel", xbar_sel, 3'b010);
         chk("w_locked", locked, 1);
      end
      tick();
      #3 chk("w_co", change_order, 1);
      chk("w_unlock", locked, 0);
      chk("w_idle_sel", xbar_sel, 3'b011);
      chk("w_credit", credit_cnt, 1);
      ret_n(3);

      // N, 6-flit packet runs out of credit
      load(3, 6);
      tick();
      grant(4'b1000);
      push_pkt(3, 6);
      repeat (5) tick();
      #3 chk("n_stall_pop", pop, 0);
      chk("n_stall_avail", credit_avail, 0);
      chk("n_stall_locked", locked, 1);
      chk("n_stall_sel", xbar_sel, 3'b000);
      credit_return = 1'b1;
      tick();
      #3 chk("n_one_pop", pop, 4'b1000);
      tick();
      #3 chk("n_hold_pop", pop, 0);
      chk("n_hold_locked", locked, 1);
      credit_return = 1'b1;
      tick();
      #3 chk("n_tail_pop", pop, 4'b1000);
      tick();
      #3 chk("n_co", change_order, 1);
      chk("n_unlock", locked, 0);

      // send and return together, then saturation
      ret_n(2);
      #3 chk("c_cnt2", credit_cnt, 2);
      load(1, 1);
      tick();
      grant(4'b0010);
      push_pkt(1, 1);
      tick();
      credit_return = 1'b1;
      #3 chk("c_pop", pop, 4'b0010);
      tick();
      #3 chk("c_same", credit_cnt, 2);
      ret_n(2);
      #3 chk("c_full", credit_cnt, 4);
      credit_return = 1'b1;
      tick();
      #3 chk("c_sat", credit_cnt, 4);

      // grant during the rotate pulse is ignored
      load(1, 1);
      load(2, 2);
      tick();
      grant(4'b0010);
      push_pkt(1, 1);
      tick();
      tick();
      grant(4'b0100);
      #3 chk("s_co", change_order, 1);
      tick();
      #3 chk("s_ignored_locked", locked, 0);
      chk("s_ignored_sel", xbar_sel, 3'b011);
      grant(4'b0100);
      push_pkt(2, 2);
      tick();
      #3 chk("s_locked", locked, 1);
      chk("s_sel", xbar_sel, 3'b001);
      chk("s_pop", pop, 4'b0100);
      tick();
      tick();
      ret_n(3);

      // several grants at once: S wins over W and L
      load(2, 1);
      tick();
      grant(4'b0111);
      push_pkt(2, 1);
      tick();
      #3 chk("pri_sel", xbar_sel, 3'b001);
      chk("pri_pop", pop, 4'b0100);
      tick();
      tick();

      // reset in the middle of a packet
      load(3, 4);
      tick();
      grant(4'b1000);
      push_pkt(3, 4);
      tick();
      tick();
      #1 rst_n = 1'b0;
      #1 chk("r_locked", locked, 0);
      chk("r_sel", xbar_sel, 3'b011);
      chk("r_pop", pop, 0);
      chk("r_valid", xbar_valid, 0);
      chk("r_credit", credit_cnt, 4);
      chk("r_avail", credit_avail, 1);
      chk("r_co", change_order, 0);
      exp_q.delete();
      for (int k = 0; k < 4; k++) buf_len[k] = 0;
      tick();
      rst_n = 1'b1;
      tick();
      #3 chk("r2_locked", locked, 0);
      chk("r2_co", change_order, 0);

`ifdef OPC_WATCHDOG_EN
      // L granted with nothing to send: watchdog forces release
      mon_co_en = 1'b0;
      tick();
      grant(4'b0001);
      tick();
      #3 chk("wd_locked", locked, 1);
      repeat (63) tick();
      #3 chk("wd_hold", locked, 1);
      chk("wd_pre", wdog_timeout, 0);
      tick();
      #3 chk("wd_release", locked, 0);
      chk("wd_co", change_order, 1);
      chk("wd_flag", wdog_timeout, 1);
      tick();
      mon_co_en = 1'b1;
      #3 chk("wd_sticky", wdog_timeout, 1);
`endif

      // randomized packets with flit bubbles and random credit returns
      bubble_en = 1'b1;
      ret_rand  = 1'b1;
      for (int p = 0; p < 40; p++) begin
         i   = $urandom_range(0, 3);
         len = $urandom_range(1, 6);
         load(i, len);
         tick();
         grant(4'(1 << i));
         push_pkt(i, len);
         drain();
      end
      bubble_en = 1'b0;
      ret_rand  = 1'b0;
      repeat (3) tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
